// File: rtl/shifter_seq_param.sv
// Multi-cycle parametrised shifter: SLL, SRA, ROR and SRL.
// An operation shifts by up to STEP bit positions per SHIFT cycle and
// publishes the result in shift_out with a one-cycle done pulse.
//
// Handshake: start is sampled on a rising edge only when the block is in
// IDLE or DONE. In SHIFT, start is ignored and never queued. busy is high
// for every SHIFT cycle. done is high for exactly the one cycle after the
// last SHIFT cycle, and shift_out is valid from that cycle onward. Both busy
// and done are decoded from registered state only.
module shifter_seq_param #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4,
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   shift_in,
    input  logic [SHAMT_W-1:0] shift_val,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   shift_out
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Operation encoding on the mode input
    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRA = 2'b01;
    localparam logic [1:0] MODE_ROR = 2'b10;
    localparam logic [1:0] MODE_SRL = 2'b11;

    // STEP is at most WIDTH/2, so it always fits in SHAMT_W bits
    localparam logic [SHAMT_W-1:0] STEP_AMT  = SHAMT_W'(STEP);
    localparam logic [SHAMT_W:0]   WIDTH_AMT = (SHAMT_W + 1)'(WIDTH);

    logic [1:0]         state;
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] count;
    logic [1:0]         op_mode;

    logic [SHAMT_W-1:0] amt;
    logic [SHAMT_W:0]   rot_left;
    logic [WIDTH-1:0]   work_next;
    logic               accept;

    // A new request is taken only when no shift is in flight
    assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);

    // One step of the shift: amt = min(STEP, remaining count)
    always_comb begin
        amt       = (count < STEP_AMT) ? count : STEP_AMT;
        // The left-shift by WIDTH when amt is 0 yields zero, so ROR by 0 is a no-op
        rot_left  = WIDTH_AMT - {1'b0, amt};
        work_next = work;
        case (op_mode)
            MODE_SLL: work_next = work << amt;
            MODE_SRA: work_next = $unsigned($signed(work) >>> amt);
            MODE_ROR: work_next = (work >> amt) | (work << rot_left);
            MODE_SRL: work_next = work >> amt;
            default:  work_next = work;
        endcase
    end

    // Sequencer: reset has priority and aborts any shift without a done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            work      <= '0;
            count     <= '0;
            op_mode   <= MODE_SLL;
            shift_out <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        work    <= shift_in;
                        count   <= shift_val;
                        op_mode <= mode;
                        state   <= ST_SHIFT;
                    end else begin
                        state   <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    work  <= work_next;
                    count <= count - amt;
                    // count == amt means this is the last step (also covers count 0)
                    if (count == amt) begin
                        shift_out <= work_next;
                        state     <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shifter_seq_param.sv
// Directed testbench for shifter_seq_param: default instance plus a STEP=4
// instance and a 32-bit instance. Expected values are hand-computed.
module tb_shifter_seq_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] shift_in = '0;
    logic [3:0]  shift_val = '0;
    logic        busy, done;
    logic [15:0] shift_out;

    logic        start4 = 1'b0;
    logic [1:0]  mode4 = 2'b00;
    logic [15:0] in4 = '0;
    logic [3:0]  val4 = '0;
    logic        busy4, done4;
    logic [15:0] out4;

    logic        start32 = 1'b0;
    logic [1:0]  mode32 = 2'b00;
    logic [31:0] in32 = '0;
    logic [4:0]  val32 = '0;
    logic        busy32, done32;
    logic [31:0] out32;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRA = 2'b01;
    localparam logic [1:0] ROR = 2'b10;
    localparam logic [1:0] SRL = 2'b11;

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    shifter_seq_param dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .shift_in(shift_in), .shift_val(shift_val),
        .busy(busy), .done(done), .shift_out(shift_out)
    );

    shifter_seq_param #(.WIDTH(16), .SHAMT_W(4), .STEP(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .mode(mode4),
        .shift_in(in4), .shift_val(val4),
        .busy(busy4), .done(done4), .shift_out(out4)
    );

    shifter_seq_param #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .mode(mode32),
        .shift_in(in32), .shift_val(val32),
        .busy(busy32), .done(done32), .shift_out(out32)
    );

    // Driver: one-cycle start pulse on the default instance, then count busy
    // cycles (sampled at negedges) until done or a cycle budget runs out.
    // Returns at the negedge on which done was seen.
    task automatic do_op(input logic [1:0] m, input logic [15:0] d,
                         input logic [3:0] v, output int nbusy,
                         output logic [15:0] res, output bit got_done);
        nbusy = 0;
        got_done = 1'b0;
        res = '0;
        @(negedge clk);
        start = 1'b1; mode = m; shift_in = d; shift_val = v;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 64 && !got_done; i++) begin
            if (done) begin
                got_done = 1'b1;
                res = shift_out;
            end else begin
                if (busy) nbusy++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || shift_out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_default: busy=%b done=%b out=%h expected 0 0 0000", busy, done, shift_out);
        end
        checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || out4 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_step4: busy=%b done=%b out=%h expected 0 0 0000", busy4, done4, out4);
        end
        checks++;
        if (busy32 !== 1'b0 || done32 !== 1'b0 || out32 !== 32'h0) begin
            errors++;
            $display("FAIL reset_wide: busy=%b done=%b out=%h expected 0 0 00000000", busy32, done32, out32);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_modes();
        int nb;
        logic [15:0] r;
        bit ok;
        logic [1:0]  t_mode [4] = '{SLL, SRA, SRL, ROR};
        logic [3:0]  t_val  [4] = '{4'd3, 4'd3, 4'd3, 4'd4};
        logic [15:0] t_exp  [4] = '{16'hDD48, 16'hF775, 16'h1775, 16'h9BBA};
        int          t_busy [4] = '{3, 3, 3, 4};
        for (int k = 0; k < 4; k++) begin
            do_op(t_mode[k], 16'hBBA9, t_val[k], nb, r, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL mode%0d_done: no done pulse seen, expected one", k);
            end
            checks++;
            if (r !== t_exp[k]) begin
                errors++;
                $display("FAIL mode%0d_result: got %h expected %h", k, r, t_exp[k]);
            end
            checks++;
            if (nb !== t_busy[k]) begin
                errors++;
                $display("FAIL mode%0d_busy_cycles: got %0d expected %0d", k, nb, t_busy[k]);
            end
            // done is a single-cycle pulse and the result is held in IDLE
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || shift_out !== t_exp[k]) begin
                errors++;
                $display("FAIL mode%0d_after_done: done=%b busy=%b out=%h expected 0 0 %h",
                         k, done, busy, shift_out, t_exp[k]);
            end
        end
    endtask

    task automatic test_zero_and_back_to_back();
        int nb;
        logic [15:0] r;
        bit ok;
        do_op(SRA, 16'h8001, 4'd0, nb, r, ok);
        checks++;
        if (!ok || r !== 16'h8001) begin
            errors++;
            $display("FAIL zero_shift_result: got %h (done seen %b) expected 8001", r, ok);
        end
        checks++;
        if (nb !== 1) begin
            errors++;
            $display("FAIL zero_shift_busy: got %0d expected 1", nb);
        end
        // start held high: SHIFT and DONE alternate with no IDLE between
        @(negedge clk);
        start = 1'b1; mode = SRA; shift_in = 16'h8001; shift_val = 4'd0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (done !== (k % 2 == 1) || busy !== (k % 2 == 0)) begin
                errors++;
                $display("FAIL back_to_back_cycle%0d: done=%b busy=%b expected %b %b",
                         k, done, busy, (k % 2 == 1), (k % 2 == 0));
            end
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        int nb;
        bit ok;
        bit held;
        logic [15:0] r;
        nb = 0; ok = 1'b0; held = 1'b1; r = '0;
        @(negedge clk);
        start = 1'b1; mode = SLL; shift_in = 16'h00FF; shift_val = 4'd5;
        @(negedge clk);
        if (busy) nb++;
        if (shift_out !== 16'h8001) held = 1'b0;
        // second request while busy must be dropped
        shift_in = 16'h1234; shift_val = 4'd1; mode = SRL;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            if (done) begin
                ok = 1'b1;
                r = shift_out;
            end else begin
                if (busy) nb++;
                if (shift_out !== 16'h8001) held = 1'b0;
                @(negedge clk);
            end
        end
        checks++;
        if (!ok || r !== 16'h1FE0) begin
            errors++;
            $display("FAIL ignore_start_result: got %h (done seen %b) expected 1fe0", r, ok);
        end
        checks++;
        if (nb !== 5) begin
            errors++;
            $display("FAIL ignore_start_busy: got %0d expected 5", nb);
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL hold_old_result: shift_out changed while busy, expected 8001 held");
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL no_queued_start: busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_reset_abort();
        bit saw_done;
        saw_done = 1'b0;
        @(negedge clk);
        start = 1'b1; mode = SLL; shift_in = 16'h0001; shift_val = 4'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || shift_out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_abort: busy=%b done=%b out=%h expected 0 0 0000", busy, done, shift_out);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL reset_abort_no_done: activity after abort, expected none");
        end
    endtask

    task automatic test_step4();
        int nb;
        bit ok;
        logic [15:0] r;
        nb = 0; ok = 1'b0; r = '0;
        @(negedge clk);
        start4 = 1'b1; mode4 = SRA; in4 = 16'h8000; val4 = 4'd15;
        @(negedge clk);
        start4 = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            if (done4) begin
                ok = 1'b1;
                r = out4;
            end else begin
                if (busy4) nb++;
                @(negedge clk);
            end
        end
        checks++;
        if (!ok || r !== 16'hFFFF) begin
            errors++;
            $display("FAIL step4_result: got %h (done seen %b) expected ffff", r, ok);
        end
        checks++;
        if (nb !== 4) begin
            errors++;
            $display("FAIL step4_busy: got %0d expected 4", nb);
        end
    endtask

    task automatic test_wide();
        int nb;
        bit ok;
        logic [31:0] r;
        nb = 0; ok = 1'b0; r = '0;
        @(negedge clk);
        start32 = 1'b1; mode32 = ROR; in32 = 32'h80000001; val32 = 5'd1;
        @(negedge clk);
        start32 = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            if (done32) begin
                ok = 1'b1;
                r = out32;
            end else begin
                if (busy32) nb++;
                @(negedge clk);
            end
        end
        checks++;
        if (!ok || r !== 32'hC0000000) begin
            errors++;
            $display("FAIL wide_ror_result: got %h (done seen %b) expected c0000000", r, ok);
        end
        checks++;
        if (nb !== 1) begin
            errors++;
            $display("FAIL wide_ror_busy: got %0d expected 1", nb);
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_zero_and_back_to_back();
        test_start_while_busy();
        test_reset_abort();
        test_step4();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
